// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: issues loads/stores on a req/ack data port and writes back through MEM/WB.
// Latency 1 cycle for non-memory ops, k+1 cycles for memory ops (ack in k-th BUSY cycle); stalls upstream while busy.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES BUSY cycles without ack and pulses mem_err.
module mem_access_stage #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] EXE_MEM_Result,
  input  logic [DATA_W-1:0] EXE_MEM_Rt,
  input  logic [4:0]        EXE_MEM_DstReg,
  input  logic              EXE_MEM_MemRead,
  input  logic              EXE_MEM_MemWrite,
  input  logic              EXE_MEM_MemtoReg,
  input  logic              EXE_MEM_RegWrite,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              mem_stall,
  output logic [DATA_W-1:0] MEM_WB_Result,
  output logic [DATA_W-1:0] MEM_WB_ReadData,
  output logic [4:0]        MEM_WB_DstReg,
  output logic              MEM_WB_MemtoReg,
  output logic              MEM_WB_RegWrite,
  output logic              mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic              req, timeout;
  logic [DATA_W-1:0] cap_result;
  logic [4:0]        cap_dst;
  logic              cap_memtoreg, cap_regwrite;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  assign req = EXE_MEM_MemRead | EXE_MEM_MemWrite;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       err_q;

  // Counter sits at 0 throughout IDLE, so it is already clear on entry to BUSY.
  assign timeout = (state_q == BUSY) && !dm_ack && (to_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign mem_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state_q == IDLE)
        to_cnt <= '0;
      else if (!dm_ack)
        to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        mem_stall = req;
        if (req) state_d = BUSY;
      end
      BUSY: begin
        mem_stall = !dm_ack && !timeout;
        if (dm_ack || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      dm_req          <= 1'b0;
      dm_we           <= 1'b0;
      dm_addr         <= '0;
      dm_wdata        <= '0;
      cap_result      <= '0;
      cap_dst         <= '0;
      cap_memtoreg    <= 1'b0;
      cap_regwrite    <= 1'b0;
      MEM_WB_Result   <= '0;
      MEM_WB_ReadData <= '0;
      MEM_WB_DstReg   <= '0;
      MEM_WB_MemtoReg <= 1'b0;
      MEM_WB_RegWrite <= 1'b0;
    end else begin
      state_q <= state_d;
      // Bubble by default; overridden when an instruction retires this edge.
      MEM_WB_Result   <= '0;
      MEM_WB_ReadData <= '0;
      MEM_WB_DstReg   <= '0;
      MEM_WB_MemtoReg <= 1'b0;
      MEM_WB_RegWrite <= 1'b0;
      if (state_q == IDLE) begin
        if (req) begin
          dm_req       <= 1'b1;
          dm_we        <= EXE_MEM_MemWrite;
          dm_addr      <= EXE_MEM_Result;
          dm_wdata     <= EXE_MEM_Rt;
          cap_result   <= EXE_MEM_Result;
          cap_dst      <= EXE_MEM_DstReg;
          cap_memtoreg <= EXE_MEM_MemtoReg;
          cap_regwrite <= EXE_MEM_RegWrite;
        end else begin
          MEM_WB_Result   <= EXE_MEM_Result;
          MEM_WB_DstReg   <= EXE_MEM_DstReg;
          MEM_WB_MemtoReg <= EXE_MEM_MemtoReg;
          MEM_WB_RegWrite <= EXE_MEM_RegWrite;
        end
      end else if (dm_ack) begin
        dm_req          <= 1'b0;
        MEM_WB_Result   <= cap_result;
        MEM_WB_ReadData <= dm_we ? '0 : dm_rdata;
        MEM_WB_DstReg   <= cap_dst;
        MEM_WB_MemtoReg <= cap_memtoreg;
        MEM_WB_RegWrite <= cap_regwrite;
      end else if (timeout) begin
        dm_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized instruction stream.
// Expected write-back and stall counts come from the instruction-level rules, not from the RTL structure.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] EXE_MEM_Result = '0, EXE_MEM_Rt = '0;
  logic [4:0]  EXE_MEM_DstReg = '0;
  logic        EXE_MEM_MemRead = 1'b0, EXE_MEM_MemWrite = 1'b0;
  logic        EXE_MEM_MemtoReg = 1'b0, EXE_MEM_RegWrite = 1'b0;
  logic        dm_req, dm_we, dm_ack = 1'b0;
  logic [31:0] dm_addr, dm_wdata, dm_rdata = '0;
  logic        mem_stall, mem_err;
  logic [31:0] MEM_WB_Result, MEM_WB_ReadData;
  logic [4:0]  MEM_WB_DstReg;
  logic        MEM_WB_MemtoReg, MEM_WB_RegWrite;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .EXE_MEM_Result(EXE_MEM_Result), .EXE_MEM_Rt(EXE_MEM_Rt), .EXE_MEM_DstReg(EXE_MEM_DstReg),
    .EXE_MEM_MemRead(EXE_MEM_MemRead), .EXE_MEM_MemWrite(EXE_MEM_MemWrite),
    .EXE_MEM_MemtoReg(EXE_MEM_MemtoReg), .EXE_MEM_RegWrite(EXE_MEM_RegWrite),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mem_stall(mem_stall),
    .MEM_WB_Result(MEM_WB_Result), .MEM_WB_ReadData(MEM_WB_ReadData),
    .MEM_WB_DstReg(MEM_WB_DstReg), .MEM_WB_MemtoReg(MEM_WB_MemtoReg),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Executes one instruction: k = BUSY cycle in which ack is given (ignored for non-memory ops).
  task automatic run_instr(input logic rd, input logic wr, input logic m2r, input logic rw,
                           input logic [4:0] dst, input logic [31:0] res, input logic [31:0] rt,
                           input int k, input logic [31:0] rdata);
    int          stalls;
    logic        is_mem;
    logic [31:0] exp_rd;
    logic [71:0] exp_wb;
    is_mem = rd | wr;
    stalls = 0;
    EXE_MEM_MemRead = rd; EXE_MEM_MemWrite = wr; EXE_MEM_MemtoReg = m2r; EXE_MEM_RegWrite = rw;
    EXE_MEM_DstReg = dst; EXE_MEM_Result = res; EXE_MEM_Rt = rt;
    dm_ack = 1'($urandom); dm_rdata = $urandom;
    @(negedge clk);
    if (mem_stall) stalls++;
    n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL dm_req_idle: got %b expected 0", dm_req); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL mem_err_idle: got %b expected 0", mem_err); end
    @(posedge clk); #1;
    if (is_mem) begin
      for (int j = 1; j <= k; j++) begin
        EXE_MEM_Result = $urandom; EXE_MEM_Rt = $urandom; EXE_MEM_DstReg = 5'($urandom);
        dm_ack = (j == k);
        dm_rdata = (j == k) ? rdata : $urandom;
        @(negedge clk);
        if (mem_stall) stalls++;
        n_checks++;
        if ({dm_req, dm_we, dm_addr, dm_wdata} !== {1'b1, wr, res, rt}) begin
          n_fail++;
          $display("FAIL dm_port: got req=%b we=%b addr=%h wdata=%h expected req=1 we=%b addr=%h wdata=%h",
                   dm_req, dm_we, dm_addr, dm_wdata, wr, res, rt);
        end
        n_checks++;
        if ({MEM_WB_Result, MEM_WB_ReadData, MEM_WB_DstReg, MEM_WB_MemtoReg, MEM_WB_RegWrite} !== 71'd0) begin
          n_fail++;
          $display("FAIL busy_bubble: got res=%h rd=%h dst=%0d m2r=%b rw=%b expected all zero",
                   MEM_WB_Result, MEM_WB_ReadData, MEM_WB_DstReg, MEM_WB_MemtoReg, MEM_WB_RegWrite);
        end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL mem_err_busy: got %b expected 0", mem_err); end
        @(posedge clk); #1;
      end
      dm_ack = 1'b0;
    end
    exp_rd = (is_mem && !wr) ? rdata : 32'd0;
    exp_wb = {res, exp_rd, dst, m2r, rw, 1'b0};
    n_checks++;
    if (stalls != (is_mem ? k : 0)) begin
      n_fail++; $display("FAIL stall_cycles: got %0d expected %0d", stalls, is_mem ? k : 0);
    end
    n_checks++;
    if ({MEM_WB_Result, MEM_WB_ReadData, MEM_WB_DstReg, MEM_WB_MemtoReg, MEM_WB_RegWrite, dm_req} !== exp_wb) begin
      n_fail++;
      $display("FAIL writeback: got res=%h rd=%h dst=%0d m2r=%b rw=%b req=%b expected res=%h rd=%h dst=%0d m2r=%b rw=%b req=0",
               MEM_WB_Result, MEM_WB_ReadData, MEM_WB_DstReg, MEM_WB_MemtoReg, MEM_WB_RegWrite, dm_req,
               res, exp_rd, dst, m2r, rw);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({dm_req, dm_we, dm_addr, dm_wdata, MEM_WB_Result, MEM_WB_ReadData, MEM_WB_DstReg,
         MEM_WB_MemtoReg, MEM_WB_RegWrite, mem_err} !== 139'd0) begin
      n_fail++; $display("FAIL reset_outputs: got req=%b addr=%h wb_res=%h expected all zero",
                         dm_req, dm_addr, MEM_WB_Result);
    end
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu;
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, $urandom, 0, 32'd0);
  endtask

  task automatic test_load;
    run_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h40, $urandom, 3, 32'hDEAD_BEEF);
  endtask

  task automatic test_store;
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h80, 32'h5A5A_5A5A, 1, $urandom);
  endtask

  task automatic test_back_to_back;
    run_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h100, $urandom, 1, 32'h1111_2222);
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h104, 32'h3333_4444, 1, $urandom);
  endtask

  task automatic test_both_bits;
    run_instr(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h200, 32'hA5A5_0F0F, 2, 32'hFFFF_FFFF);
  endtask

  task automatic test_reset_mid;
    EXE_MEM_MemRead = 1'b1; EXE_MEM_MemWrite = 1'b0; EXE_MEM_MemtoReg = 1'b1; EXE_MEM_RegWrite = 1'b1;
    EXE_MEM_DstReg = 5'd9; EXE_MEM_Result = 32'h300; dm_ack = 1'b0;
    @(posedge clk); #2;
    n_checks++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL req_before_reset: got %b expected 1", dm_req); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dm_req, MEM_WB_Result, MEM_WB_ReadData, MEM_WB_DstReg, MEM_WB_MemtoReg, MEM_WB_RegWrite} !== 72'd0) begin
      n_fail++; $display("FAIL async_reset: got req=%b wb_res=%h rw=%b expected all zero",
                         dm_req, MEM_WB_Result, MEM_WB_RegWrite);
    end
    EXE_MEM_MemRead = 1'b0; EXE_MEM_MemtoReg = 1'b0; EXE_MEM_Result = 32'hCAFE;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall: got %b expected 0", mem_stall); end
    @(posedge clk); #1;
    n_checks++;
    if ({MEM_WB_Result, MEM_WB_RegWrite, MEM_WB_DstReg} !== {32'hCAFE, 1'b1, 5'd9}) begin
      n_fail++; $display("FAIL post_reset_idle: got res=%h rw=%b dst=%0d expected res=0000cafe rw=1 dst=9",
                         MEM_WB_Result, MEM_WB_RegWrite, MEM_WB_DstReg);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    EXE_MEM_MemRead = 1'b1; EXE_MEM_MemWrite = 1'b0; EXE_MEM_MemtoReg = 1'b1; EXE_MEM_RegWrite = 1'b1;
    EXE_MEM_DstReg = 5'd4; EXE_MEM_Result = 32'h500; dm_ack = 1'b0;
    @(posedge clk); #1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      n_checks++;
      if (mem_stall !== (j < 4)) begin n_fail++; $display("FAIL timeout_stall: cycle %0d got %b expected %b", j, mem_stall, j < 4); end
      @(posedge clk); #1;
    end
    n_checks++;
    if ({dm_req, mem_err, MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_Result, MEM_WB_DstReg} !== {1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0}) begin
      n_fail++; $display("FAIL timeout_abort: got req=%b err=%b rw=%b res=%h expected req=0 err=1 rw=0 res=0",
                         dm_req, mem_err, MEM_WB_RegWrite, MEM_WB_Result);
    end
    EXE_MEM_MemRead = 1'b0; EXE_MEM_MemtoReg = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 0", mem_err); end
    run_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h504, $urandom, 4, 32'h7777_8888);
  endtask
`else
  task automatic test_long_wait;
    run_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h600, $urandom, 10, 32'h0BAD_F00D);
  endtask
`endif

  task automatic test_random;
    logic rd, wr;
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom); wr = 1'($urandom);
      run_instr(rd, wr, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
                int'($urandom_range(1, 4)), $urandom);
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_back_to_back;
    test_both_bits;
    test_reset_mid;
`ifdef MEM_TIMEOUT_EN
    test_timeout;
`else
    test_long_wait;
`endif
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
